// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : td4_pkg
// Purpose  : Shared definitions for the TD4 4-bit CPU core: opcode
//            constants, FSM state encoding and the default reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package td4_pkg;

   localparam logic [3:0] c_reset_pc_default = 4'h0;

   // Opcodes, IR[7:4]. 1000, 1010, 1100 and 1101 are not listed and execute as NOP.
   localparam logic [3:0] c_op_add_a  = 4'b0000;  // A <= A + Im
   localparam logic [3:0] c_op_mov_ab = 4'b0001;  // A <= B
   localparam logic [3:0] c_op_in_a   = 4'b0010;  // A <= in_port
   localparam logic [3:0] c_op_mov_a  = 4'b0011;  // A <= Im
   localparam logic [3:0] c_op_mov_ba = 4'b0100;  // B <= A
   localparam logic [3:0] c_op_add_b  = 4'b0101;  // B <= B + Im
   localparam logic [3:0] c_op_in_b   = 4'b0110;  // B <= in_port
   localparam logic [3:0] c_op_mov_b  = 4'b0111;  // B <= Im
   localparam logic [3:0] c_op_out_b  = 4'b1001;  // OUT <= B
   localparam logic [3:0] c_op_out_im = 4'b1011;  // OUT <= Im
   localparam logic [3:0] c_op_jnc    = 4'b1110;  // PC <= Im if carry clear
   localparam logic [3:0] c_op_jmp    = 4'b1111;  // PC <= Im

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } td4_state_e;

endpackage : td4_pkg
`default_nettype wire

// File: rtl/td4_alu.sv
`default_nettype none
// ============================================================================
// Module   : td4_alu
// Purpose  : 4-bit adder for the TD4 core. Operand selection lives in the
//            core; this block only adds.
// Ports    : a, b  (in,  4) - addends
//            sum   (out, 4) - a + b modulo 16
//            cout  (out, 1) - carry out of bit 3
// Revision : 1.0 - initial release
// ============================================================================
module td4_alu (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   assign sum      = full_sum[3:0];
   assign cout     = full_sum[4];

endmodule : td4_alu
`default_nettype wire

// File: rtl/td4_core.sv
`default_nettype none
// ============================================================================
// Module   : td4_core
// Purpose  : TD4 4-bit CPU. Each instruction takes a FETCH and an EXEC state,
//            and both transitions are gated by the step clock enable.
//            Optional macro TD4_HALT_EN adds a HALT state entered on a
//            JMP-to-self, plus the halted output.
// Ports    : clk      (in,  1) - system clock, rising edge
//            n_reset  (in,  1) - synchronous active-low reset
//            step     (in,  1) - clock enable for the FSM
//            rom_addr (out, 4) - program ROM address (= PC)
//            rom_data (in,  8) - instruction byte at rom_addr
//            in_port  (in,  4) - input switches
//            out_port (out, 4) - registered output LEDs
//            carry    (out, 1) - registered carry flag
//            halted   (out, 1) - core frozen in HALT (TD4_HALT_EN only)
//            retire   (out, 1) - one-cycle pulse after each EXEC edge
// Revision : 1.0 - initial release
// ============================================================================
module td4_core
   import td4_pkg::*;
#(
   parameter logic [3:0] RESET_PC = c_reset_pc_default
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       step,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] in_port,
   output logic [3:0] out_port,
   output logic       carry,
`ifdef TD4_HALT_EN
   output logic       halted,
`endif
   output logic       retire
);

   td4_state_e state_q, state_d;
   logic [3:0] pc_q,     pc_d;
   logic [7:0] ir_q,     ir_d;
   logic [3:0] a_q,      a_d;
   logic [3:0] b_q,      b_d;
   logic [3:0] out_q,    out_d;
   logic       carry_q,  carry_d;
   logic       retire_q, retire_d;

   logic [3:0] opcode;
   logic [3:0] im;
   logic [3:0] pc_inc;
   logic [3:0] alu_a;
   logic [3:0] alu_sum;
   logic       alu_cout;

   assign opcode = ir_q[7:4];
   assign im     = ir_q[3:0];
   assign pc_inc = pc_q + 4'd1;   // wraps F -> 0 naturally

   // Only the two ADD opcodes use the adder; the immediate is always the
   // second addend, so only the first operand needs selecting.
   assign alu_a = (opcode == c_op_add_b) ? b_q : a_q;

   td4_alu u_alu (
      .a    (alu_a),
      .b    (im),
      .sum  (alu_sum),
      .cout (alu_cout)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      carry_d  = carry_q;
      retire_d = 1'b0;   // pulse output: never held across step=0 edges

      if (step) begin
         case (state_q)
            ST_FETCH: begin
               ir_d    = rom_data;
               state_d = ST_EXEC;
            end

            ST_EXEC: begin
               state_d  = ST_FETCH;
               retire_d = 1'b1;
               carry_d  = 1'b0;   // every non-ADD instruction clears carry
               pc_d     = pc_inc;

               case (opcode)
                  c_op_add_a: begin
                     a_d     = alu_sum;
                     carry_d = alu_cout;
                  end
                  c_op_mov_ab: a_d = b_q;
                  c_op_in_a:   a_d = in_port;
                  c_op_mov_a:  a_d = im;
                  c_op_mov_ba: b_d = a_q;
                  c_op_add_b: begin
                     b_d     = alu_sum;
                     carry_d = alu_cout;
                  end
                  c_op_in_b:   b_d = in_port;
                  c_op_mov_b:  b_d = im;
                  c_op_out_b:  out_d = b_q;
                  c_op_out_im: out_d = im;
                  c_op_jnc: begin
                     // Decision uses the carry left by the previous instruction.
                     if (!carry_q) begin
                        pc_d = im;
                     end
                  end
                  c_op_jmp: begin
                     pc_d = im;
`ifdef TD4_HALT_EN
                     // JMP-to-self parks the core; the halting instruction
                     // does not pulse retire so retire stays low once halted.
                     if (im == pc_q) begin
                        state_d  = ST_HALT;
                        retire_d = 1'b0;
                        pc_d     = pc_q;
                     end
`endif
                  end
                  default: ;   // NOP opcodes
               endcase
            end

            default: ;   // ST_HALT: everything frozen until reset
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= 8'h00;
         a_q      <= 4'h0;
         b_q      <= 4'h0;
         out_q    <= 4'h0;
         carry_q  <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         out_q    <= out_d;
         carry_q  <= carry_d;
         retire_q <= retire_d;
      end
   end

   assign rom_addr = pc_q;
   assign out_port = out_q;
   assign carry    = carry_q;
   assign retire   = retire_q;
`ifdef TD4_HALT_EN
   assign halted   = (state_q == ST_HALT);
`endif

endmodule : td4_core
`default_nettype wire

// File: tb/tb_td4_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_core
// Purpose  : Directed self-checking bench for td4_core with a combinational
//            16x8 program ROM. Define TD4_HALT_EN to exercise the HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_core;
   import td4_pkg::*;

   logic       clk;
   logic       n_reset;
   logic       step;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [3:0] in_port;
   logic [3:0] out_port;
   logic       carry;
   logic       retire;
`ifdef TD4_HALT_EN
   logic       halted;
`endif

   logic [7:0] rom [16];

   int n_checks = 0;
   int n_pass   = 0;

   assign rom_data = rom[rom_addr];

   td4_core #(.RESET_PC(4'h0)) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .step     (step),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .in_port  (in_port),
      .out_port (out_port),
      .carry    (carry),
`ifdef TD4_HALT_EN
      .halted   (halted),
`endif
      .retire   (retire)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Fill the ROM with NOP (0x80) so unused addresses are harmless.
   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h80;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      step    = 1'b1;
      tick(1);
      n_reset = 1'b1;
   endtask

   int first_ret;
   int second_ret;
   int ret_count;

   initial begin
      n_reset = 1'b0;
      step    = 1'b0;
      in_port = 4'h0;
      clear_rom();
      @(negedge clk);

      // ---- Reset state ----
      do_reset();
      check("rst_pc",     8'(rom_addr),      8'h0);
      check("rst_out",    8'(out_port),      8'h0);
      check("rst_carry",  8'(carry),         8'h0);
      check("rst_retire", 8'(retire),        8'h0);
      check("rst_a",      8'(dut.a_q),       8'h0);
      check("rst_b",      8'(dut.b_q),       8'h0);
      check("rst_state",  8'(dut.state_q),   8'(ST_FETCH));

      // ---- MOV A,10; ADD A,5 -> A=F, carry=0 ----
      clear_rom();
      rom[0] = 8'h3A; rom[1] = 8'h05;
      do_reset();
      tick(4);
      check("add_nc_a",     8'(dut.a_q), 8'hF);
      check("add_nc_carry", 8'(carry),   8'h0);

      // ---- MOV A,15; ADD A,1 -> A=0, carry=1 ----
      clear_rom();
      rom[0] = 8'h3F; rom[1] = 8'h01;
      do_reset();
      tick(4);
      check("add_c_a",     8'(dut.a_q), 8'h0);
      check("add_c_carry", 8'(carry),   8'h1);
      tick(2);   // NOP clears carry
      check("nop_clr_carry", 8'(carry), 8'h0);

      // ---- OUT 7; ADD A,1; JNC 1 loop ----
      clear_rom();
      rom[0] = 8'hB7; rom[1] = 8'h01; rom[2] = 8'hE1;
      do_reset();
      tick(2);
      check("loop_out", 8'(out_port), 8'h7);
      tick(60);   // 15 ADD/JNC iterations
      check("loop15_pc", 8'(rom_addr),  8'h1);
      check("loop15_a",  8'(dut.a_q),   8'hF);
      tick(2);    // 16th ADD overflows
      check("loop16_a",     8'(dut.a_q), 8'h0);
      check("loop16_carry", 8'(carry),   8'h1);
      tick(2);    // JNC falls through, clears carry
      check("loop_exit_pc",    8'(rom_addr), 8'h3);
      check("loop_exit_carry", 8'(carry),    8'h0);

      // ---- Mixed register moves / B arithmetic / OUT B / JMP ----
      clear_rom();
      rom[0] = 8'h3C; rom[1] = 8'h05; rom[2] = 8'h80; rom[3] = 8'h40;
      rom[4] = 8'h5F; rom[5] = 8'h7A; rom[6] = 8'h10; rom[7] = 8'h98;
      rom[8] = 8'hF0;
      do_reset();
      tick(2);
      check("mix_mov_a", 8'(dut.a_q), 8'hC);
      check("mix_retire", 8'(retire), 8'h1);
      tick(1);
      check("mix_retire_low", 8'(retire), 8'h0);
      tick(1);
      check("mix_add_a",     8'(dut.a_q), 8'h1);
      check("mix_add_carry", 8'(carry),   8'h1);
      tick(4);
      check("mix_mov_ba", 8'(dut.b_q), 8'h1);
      tick(2);
      check("mix_add_b",       8'(dut.b_q), 8'h0);
      check("mix_add_b_carry", 8'(carry),   8'h1);
      tick(2);
      check("mix_mov_b", 8'(dut.b_q), 8'hA);
      tick(2);
      check("mix_mov_ab", 8'(dut.a_q), 8'hA);
      tick(2);
      check("mix_out_b", 8'(out_port), 8'hA);
      check("mix_pc8",   8'(rom_addr), 8'h8);
      tick(2);
      check("mix_jmp_pc", 8'(rom_addr), 8'h0);

      // ---- PC wrap F -> 0 across an all-NOP ROM ----
      clear_rom();
      do_reset();
      tick(30);
      check("wrap_pc_f", 8'(rom_addr), 8'hF);
      tick(2);
      check("wrap_pc_0", 8'(rom_addr), 8'h0);

      // ---- step 1-of-4: same result, retire pulses 8 clk apart ----
      clear_rom();
      rom[0] = 8'h3A; rom[1] = 8'h05;
      do_reset();
      first_ret  = -1;
      second_ret = -1;
      ret_count  = 0;
      for (int i = 0; i < 16; i++) begin
         step = (i % 4 == 0);
         tick(1);
         if (retire) begin
            ret_count++;
            if (first_ret < 0) first_ret = i;
            else second_ret = i;
         end
      end
      step = 1'b1;
      check("slow_a",         8'(dut.a_q),              8'hF);
      check("slow_carry",     8'(carry),                8'h0);
      check("slow_pc",        8'(rom_addr),             8'h2);
      check("slow_ret_count", 8'(ret_count),            8'h2);
      check("slow_ret_gap",   8'(second_ret - first_ret), 8'h8);

      // ---- IN B; OUT B: in_port sampled only in EXEC ----
      clear_rom();
      rom[0] = 8'h60; rom[1] = 8'h90;
      do_reset();
      in_port = 4'h3;
      tick(1);            // FETCH edge
      in_port = 4'h9;
      tick(1);            // EXEC edge samples 9
      in_port = 4'h0;
      check("in_b", 8'(dut.b_q), 8'h9);
      tick(2);
      check("in_out", 8'(out_port), 8'h9);

      // ---- Reset during EXEC of MOV A,5 ----
      clear_rom();
      rom[0] = 8'hB6; rom[1] = 8'h35;
      do_reset();
      tick(2);
      check("mid_out_pre", 8'(out_port), 8'h6);
      tick(1);
      check("mid_state_exec", 8'(dut.state_q), 8'(ST_EXEC));
      n_reset = 1'b0;
      tick(1);
      n_reset = 1'b1;
      check("mid_a",      8'(dut.a_q),     8'h0);
      check("mid_pc",     8'(rom_addr),    8'h0);
      check("mid_out",    8'(out_port),    8'h0);
      check("mid_state",  8'(dut.state_q), 8'(ST_FETCH));
      check("mid_retire", 8'(retire),      8'h0);

      // ---- JMP-to-self at address 3 ----
      clear_rom();
      rom[3] = 8'hF3;
      do_reset();
      tick(8);
`ifdef TD4_HALT_EN
      check("halt_flag", 8'(halted),   8'h1);
      check("halt_pc",   8'(rom_addr), 8'h3);
      for (int i = 0; i < 10; i++) begin
         if (retire !== 1'b0 || rom_addr !== 4'h3) begin
            check("halt_frozen", {3'b0, retire, rom_addr}, 8'h03);
         end
         tick(1);
      end
      check("halt_still",  8'(halted),   8'h1);
      check("halt_pc_end", 8'(rom_addr), 8'h3);
      check("halt_ret",    8'(retire),   8'h0);
`else
      check("jself_pc",     8'(rom_addr), 8'h3);
      check("jself_retire", 8'(retire),   8'h1);
      tick(4);
      check("jself_pc2",    8'(rom_addr), 8'h3);
      check("jself_state",  8'(dut.state_q), 8'(ST_FETCH));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_td4_core
`default_nettype wire
